llr_out_serializer: RTL and testbench

Output-side consumer for the `x1` ML detector. It captures the eight parallel LLRs that `x1` presents on each `o_valid` pulse and double-buffers them. It then streams them out one per cycle, as saturated 8-bit soft values with a hard bit, under a valid/ready handshake toward the top-level read port. The block sits between `x1` and the chip output pins, replacing the bench-side LLR readout.

---
 rtl/llr_pkg.sv | 26 ++
 rtl/llr_sat_quant.sv | 28 ++
 rtl/llr_out_serializer.sv | 153 +++++++++++++++
 tb/tb_llr_out_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/llr_pkg.sv
// Shared constants, FSM state type and element ordering for the LLR output serializer.
package llr_pkg;

  localparam int DATA_WIDTH = 20;
  localparam int LLR_W      = DATA_WIDTH + 2;
  localparam int LLR_OUT_W  = 8;
  localparam int LLR_SHIFT  = 14;
  localparam int GROUP_LEN  = 8;
  localparam int IDX_W      = $clog2(GROUP_LEN);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Output order of the detector LLRs within one group.
  localparam logic [IDX_W-1:0] EL_X11 = IDX_W'(0);
  localparam logic [IDX_W-1:0] EL_X12 = IDX_W'(1);
  localparam logic [IDX_W-1:0] EL_X21 = IDX_W'(2);
  localparam logic [IDX_W-1:0] EL_X22 = IDX_W'(3);
  localparam logic [IDX_W-1:0] EL_X31 = IDX_W'(4);
  localparam logic [IDX_W-1:0] EL_X32 = IDX_W'(5);
  localparam logic [IDX_W-1:0] EL_X41 = IDX_W'(6);
  localparam logic [IDX_W-1:0] EL_X42 = IDX_W'(7);

endpackage

// File: rtl/llr_sat_quant.sv
// Arithmetic shift, clamp to the soft-output range, and hard-bit extraction from the source sign.
module llr_sat_quant
  import llr_pkg::*;
(
  input  logic [LLR_W-1:0]     src,
  output logic [LLR_OUT_W-1:0] llr,
  output logic                 hb
);

  localparam int MAX_INT = 2 ** (LLR_OUT_W - 1) - 1;
  localparam logic signed [LLR_W-1:0] MAX_V = LLR_W'(MAX_INT);
  localparam logic signed [LLR_W-1:0] MIN_V = LLR_W'(-MAX_INT - 1);

  logic signed [LLR_W-1:0] shifted;

  assign shifted = $signed(src) >>> LLR_SHIFT;
  assign hb      = src[LLR_W-1];

  always_comb begin
    llr = shifted[LLR_OUT_W-1:0];
    if (shifted > MAX_V) begin
      llr = MAX_V[LLR_OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      llr = MIN_V[LLR_OUT_W-1:0];
    end
  end

endmodule

// File: rtl/llr_out_serializer.sv
// Double-buffered capture of eight detector LLRs per group, streamed out one quantized
// element per cycle through a registered valid/ready output stage.
module llr_out_serializer
  import llr_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [LLR_W-1:0]     i_llr_x11,
  input  logic [LLR_W-1:0]     i_llr_x12,
  input  logic [LLR_W-1:0]     i_llr_x21,
  input  logic [LLR_W-1:0]     i_llr_x22,
  input  logic [LLR_W-1:0]     i_llr_x31,
  input  logic [LLR_W-1:0]     i_llr_x32,
  input  logic [LLR_W-1:0]     i_llr_x41,
  input  logic [LLR_W-1:0]     i_llr_x42,
  input  logic                 i_rd_rdy,
  output logic                 o_rd_vld,
  output logic [LLR_OUT_W-1:0] o_llr,
  output logic                 o_hb,
  output logic                 o_last,
  output logic                 o_overflow
);

  logic [LLR_W-1:0]     in_arr   [GROUP_LEN];
  logic [LLR_W-1:0]     bank_mem [2][GROUP_LEN];
  logic [1:0]           full_reg, full_next;
  logic                 wr_ptr_reg, rd_ptr_reg;
  logic [IDX_W-1:0]     idx_reg;
  state_t               state_reg;
  logic                 rd_vld_reg, hb_reg, last_reg, overflow_reg;
  logic [LLR_OUT_W-1:0] llr_reg;

  logic                 handshake, free, accept, send_next, ld_en, ld_ptr;
  logic [IDX_W-1:0]     ld_idx;
  logic [LLR_W-1:0]     ld_src;
  logic [LLR_OUT_W-1:0] q_llr;
  logic                 q_hb;

  assign in_arr[EL_X11] = i_llr_x11;
  assign in_arr[EL_X12] = i_llr_x12;
  assign in_arr[EL_X21] = i_llr_x21;
  assign in_arr[EL_X22] = i_llr_x22;
  assign in_arr[EL_X31] = i_llr_x31;
  assign in_arr[EL_X32] = i_llr_x32;
  assign in_arr[EL_X41] = i_llr_x41;
  assign in_arr[EL_X42] = i_llr_x42;

  assign handshake = rd_vld_reg & i_rd_rdy;
  assign free      = handshake & (idx_reg == EL_X42);
  // A full write bank is still usable when it is the one being released this cycle.
  assign accept    = i_valid & (~full_reg[wr_ptr_reg] | (free & (wr_ptr_reg == rd_ptr_reg)));

  always_comb begin
    full_next = full_reg;
    if (free) full_next[rd_ptr_reg] = 1'b0;
    if (accept) full_next[wr_ptr_reg] = 1'b1;

    ld_en     = 1'b0;
    ld_ptr    = rd_ptr_reg;
    ld_idx    = idx_reg;
    send_next = (state_reg == SEND);
    if (state_reg == IDLE) begin
      if (full_next[rd_ptr_reg]) begin
        ld_en     = 1'b1;
        ld_idx    = EL_X11;
        send_next = 1'b1;
      end
    end else if (handshake) begin
      if (free) begin
        ld_ptr    = ~rd_ptr_reg;
        ld_idx    = EL_X11;
        send_next = full_next[~rd_ptr_reg];
        ld_en     = full_next[~rd_ptr_reg];
      end else begin
        ld_idx = idx_reg + IDX_W'(1);
        ld_en  = 1'b1;
      end
    end

    // Bypass the bank when the element to present is being captured in this same cycle.
    if (accept && (wr_ptr_reg == ld_ptr)) begin
      ld_src = in_arr[ld_idx];
    end else begin
      ld_src = bank_mem[ld_ptr][ld_idx];
    end
  end

  llr_sat_quant u_quant (
    .src (ld_src),
    .llr (q_llr),
    .hb  (q_hb)
  );

  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int e = 0; e < GROUP_LEN; e++) begin
        bank_mem[wr_ptr_reg][e] <= in_arr[e];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      full_reg     <= 2'b00;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      idx_reg      <= EL_X11;
      rd_vld_reg   <= 1'b0;
      llr_reg      <= '0;
      hb_reg       <= 1'b0;
      last_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
      if (accept) wr_ptr_reg <= ~wr_ptr_reg;
      if (i_valid && !accept) overflow_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          idx_reg <= EL_X11;
          if (send_next) state_reg <= SEND;
        end
        SEND: begin
          if (handshake) begin
            if (free) begin
              rd_ptr_reg <= ~rd_ptr_reg;
              idx_reg    <= EL_X11;
              if (!send_next) state_reg <= IDLE;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
      endcase

      rd_vld_reg <= send_next;
      if (ld_en) begin
        llr_reg  <= q_llr;
        hb_reg   <= q_hb;
        last_reg <= (ld_idx == EL_X42);
      end
    end
  end

  assign o_rd_vld   = rd_vld_reg;
  assign o_llr      = llr_reg;
  assign o_hb       = hb_reg;
  assign o_last     = last_reg;
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_llr_out_serializer.sv
// Directed bench for llr_out_serializer: quantization, backpressure, overflow, bank hand-over and reset.
module tb_llr_out_serializer;
  import llr_pkg::*;

  logic                 i_clk = 1'b0;
  logic                 i_reset, i_valid, i_rd_rdy;
  logic [LLR_W-1:0]     i_llr_x11, i_llr_x12, i_llr_x21, i_llr_x22;
  logic [LLR_W-1:0]     i_llr_x31, i_llr_x32, i_llr_x41, i_llr_x42;
  logic                 o_rd_vld, o_hb, o_last, o_overflow;
  logic [LLR_OUT_W-1:0] o_llr;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [9:0] obs_q[$];

  always #5 i_clk = ~i_clk;

  llr_out_serializer dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_llr_x11  (i_llr_x11),
    .i_llr_x12  (i_llr_x12),
    .i_llr_x21  (i_llr_x21),
    .i_llr_x22  (i_llr_x22),
    .i_llr_x31  (i_llr_x31),
    .i_llr_x32  (i_llr_x32),
    .i_llr_x41  (i_llr_x41),
    .i_llr_x42  (i_llr_x42),
    .i_rd_rdy   (i_rd_rdy),
    .o_rd_vld   (o_rd_vld),
    .o_llr      (o_llr),
    .o_hb       (o_hb),
    .o_last     (o_last),
    .o_overflow (o_overflow)
  );

  // Inputs only change just after a rising edge, so this sees the handshake of the next edge.
  always @(negedge i_clk) begin
    if (!i_reset && o_rd_vld && i_rd_rdy) begin
      obs_q.push_back({o_last, o_hb, o_llr});
      $display("handshake llr=%02h hb=%0d last=%0d", o_llr, o_hb, o_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_group(input logic [7:0][LLR_W-1:0] g);
    i_llr_x11 = g[0]; i_llr_x12 = g[1]; i_llr_x21 = g[2]; i_llr_x22 = g[3];
    i_llr_x31 = g[4]; i_llr_x32 = g[5]; i_llr_x41 = g[6]; i_llr_x42 = g[7];
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  function automatic logic [7:0][LLR_W-1:0] ramp(input int base);
    logic [7:0][LLR_W-1:0] g;
    for (int e = 0; e < 8; e++) g[e] = LLR_W'((base + e) << LLR_SHIFT);
    return g;
  endfunction

  // Expects n handshakes carrying soft values base, base+1, ... with last on every 8th.
  task automatic check_stream(input string tag, input int base, input int n);
    logic [9:0] exp_v;
    check({tag, "_count"}, obs_q.size(), n);
    for (int e = 0; e < obs_q.size() && e < n; e++) begin
      exp_v = {(e % 8 == 7), 1'b0, 8'(base + e)};
      check({tag, "_elem"}, obs_q[e], exp_v);
    end
  endtask

  initial begin
    logic [7:0][LLR_W-1:0] g;
    int vld_cnt;

    i_reset = 1'b1; i_valid = 1'b0; i_rd_rdy = 1'b0;
    i_llr_x11 = '0; i_llr_x12 = '0; i_llr_x21 = '0; i_llr_x22 = '0;
    i_llr_x31 = '0; i_llr_x32 = '0; i_llr_x41 = '0; i_llr_x42 = '0;
    repeat (3) tick();
    check("rst_vld", o_rd_vld, 0);
    check("rst_llr", o_llr, 0);
    check("rst_hb", o_hb, 0);
    check("rst_last", o_last, 0);
    check("rst_ovf", o_overflow, 0);
    i_reset = 1'b0;
    tick();

    // Single group, ready held high.
    i_rd_rdy = 1'b1;
    obs_q.delete();
    g = '0; g[0] = 22'h004000; g[1] = 22'h3FC000;
    drive_group(g);
    check("t1_vld0", o_rd_vld, 1);
    check("t1_llr0", o_llr, 8'h01);
    check("t1_hb0", o_hb, 0);
    check("t1_last0", o_last, 0);
    tick();
    check("t1_llr1", o_llr, 8'hFF);
    check("t1_hb1", o_hb, 1);
    check("t1_last1", o_last, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t1_llr_zero", o_llr, 8'h00);
      check("t1_hb_zero", o_hb, 0);
      check("t1_last", o_last, (k == 5));
    end
    tick();
    check("t1_idle", o_rd_vld, 0);
    check("t1_count", obs_q.size(), 8);

    // Saturation extremes.
    g = '0; g[0] = 22'h1FFFFF; g[1] = 22'h200000;
    drive_group(g);
    check("sat_pos_llr", o_llr, 8'h7F);
    check("sat_pos_hb", o_hb, 0);
    tick();
    check("sat_neg_llr", o_llr, 8'h80);
    check("sat_neg_hb", o_hb, 1);
    repeat (7) tick();
    check("sat_idle", o_rd_vld, 0);

    // Backpressure at idx=3.
    obs_q.delete();
    drive_group(ramp(1));
    repeat (3) tick();
    check("bp_idx3", o_llr, 8'd4);
    i_rd_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_vld", o_rd_vld, 1);
      check("bp_hold_llr", o_llr, 8'd4);
      check("bp_hold_last", o_last, 0);
    end
    i_rd_rdy = 1'b1;
    repeat (6) tick();
    check("bp_idle", o_rd_vld, 0);
    check_stream("bp", 1, 8);

    // Overflow: three groups with no reads.
    i_rd_rdy = 1'b0;
    obs_q.delete();
    drive_group(ramp(1));
    drive_group(ramp(9));
    check("ovf_before", o_overflow, 0);
    drive_group(ramp(17));
    check("ovf_set", o_overflow, 1);
    i_rd_rdy = 1'b1;
    repeat (20) tick();
    check("ovf_idle", o_rd_vld, 0);
    check("ovf_sticky", o_overflow, 1);
    check_stream("ovf", 1, 16);

    // New group lands in the freed bank on the final handshake.
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("sim_ovf_clr", o_overflow, 0);
    i_rd_rdy = 1'b0;
    obs_q.delete();
    drive_group(ramp(1));
    drive_group(ramp(9));
    i_rd_rdy = 1'b1;
    repeat (7) tick();
    check("sim_at_last_llr", o_llr, 8'd8);
    check("sim_at_last", o_last, 1);
    drive_group(ramp(17));
    check("sim_no_ovf", o_overflow, 0);
    vld_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (o_rd_vld) vld_cnt++;
      tick();
    end
    check("sim_no_gap", vld_cnt, 16);
    check("sim_idle", o_rd_vld, 0);
    check_stream("sim", 1, 24);

    // Reset in the middle of a group.
    obs_q.delete();
    drive_group(ramp(1));
    repeat (4) tick();
    check("rmid_idx4", o_llr, 8'd5);
    i_reset = 1'b1;
    tick();
    check("rmid_vld", o_rd_vld, 0);
    check("rmid_llr", o_llr, 0);
    check("rmid_hb", o_hb, 0);
    check("rmid_last", o_last, 0);
    i_reset = 1'b0;
    repeat (2) tick();
    check("rmid_empty", o_rd_vld, 0);
    drive_group(ramp(9));
    check("rmid_restart_vld", o_rd_vld, 1);
    check("rmid_restart_llr", o_llr, 8'd9);
    check("rmid_restart_last", o_last, 0);
    repeat (8) tick();
    check("rmid_idle", o_rd_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
